char_blitter: RTL and testbench

- Client-side reader of the character bitmap ROM: accepts one "draw character C at cell (col,row)" request, issues the ROM read (charprint/character), captures the returned 64-bit 8x8 bitmap, and writes it into the video framebuffer one 8-pixel line per cycle.
- Sits between the MIPS-side video character-map register interface and the framebuffer write port; the ROM itself is unchanged.

---
 rtl/char_blitter.sv | 179 +++++++++++++++++
 tb/tb_char_blitter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/char_blitter.sv
// Character blitter: fetches an 8x8 glyph from the bitmap ROM and writes it
// into the framebuffer one 8-pixel line per cycle.
module char_blitter #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 60,
  parameter int unsigned NCHARS = 40,
  parameter int unsigned FB_AW  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_char,
  input  logic [6:0]       req_col,
  input  logic [5:0]       req_row,
  output logic             charprint,
  output logic [5:0]       character,
  input  logic [63:0]      vdata,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [7:0]       fb_wdata,
  output logic             done,
  output logic             err
);

  localparam int unsigned LINES     = 8;
  localparam logic [7:0]  COLS_C    = 8'(COLS);
  localparam logic [6:0]  ROWS_C    = 7'(ROWS);
  localparam logic [6:0]  NCHARS_C  = 7'(NCHARS);
  localparam logic [2:0]  LAST_LINE = 3'(LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_FETCH,
    S_LOAD,
    S_WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        char_q, char_d;
  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic              blank_q, blank_d;
  logic [63:0]       bitmap_q, bitmap_d;
  logic [2:0]        line_q, line_d;
  logic              charprint_q, charprint_d;
  logic [5:0]        character_q, character_d;
  logic              fb_we_q, fb_we_d;
  logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
  logic [7:0]        fb_wdata_q, fb_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [63:0]       load_v;
  logic [63:0]       next_line_v;
  logic [FB_AW-1:0]  base_addr;
  logic              bad_cell;
  logic              blank_glyph;

  assign req_ready = (state_q == S_IDLE);

  // Address of line 0 of the target cell.
  assign base_addr   = FB_AW'(row_q) * FB_AW'(COLS * LINES) + FB_AW'(col_q);
  assign bad_cell    = ({1'b0, col_q} >= COLS_C) || ({1'b0, row_q} >= ROWS_C);
  assign blank_glyph = ({1'b0, char_q} >= NCHARS_C);

  always_comb begin
    state_d     = state_q;
    char_d      = char_q;
    col_d       = col_q;
    row_d       = row_q;
    blank_d     = blank_q;
    bitmap_d    = bitmap_q;
    line_d      = line_q;
    charprint_d = 1'b0;
    character_d = character_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_wdata_d  = fb_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load_v      = blank_q ? 64'd0 : vdata;
    next_line_v = bitmap_q << {3'(line_q + 3'd1), 3'b000};

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          char_d  = req_char;
          col_d   = req_col;
          row_d   = req_row;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_cell) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (blank_glyph) begin
          // Out-of-range glyph codes draw an empty cell without touching the ROM.
          blank_d = 1'b1;
          state_d = S_LOAD;
        end else begin
          blank_d     = 1'b0;
          charprint_d = 1'b1;
          character_d = char_q;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        bitmap_d   = load_v;
        line_d     = 3'd0;
        fb_we_d    = 1'b1;
        fb_wdata_d = load_v[63:56];
        fb_addr_d  = base_addr;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (line_q == LAST_LINE) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          line_d     = line_q + 3'd1;
          fb_we_d    = 1'b1;
          fb_wdata_d = next_line_v[63:56];
          fb_addr_d  = fb_addr_q + FB_AW'(COLS);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      char_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      blank_q     <= 1'b0;
      bitmap_q    <= '0;
      line_q      <= '0;
      charprint_q <= 1'b0;
      character_q <= '0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      char_q      <= char_d;
      col_q       <= col_d;
      row_q       <= row_d;
      blank_q     <= blank_d;
      bitmap_q    <= bitmap_d;
      line_q      <= line_d;
      charprint_q <= charprint_d;
      character_q <= character_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign charprint = charprint_q;
  assign character = character_q;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_char_blitter.sv
// Self-checking bench for char_blitter: ROM model, event monitor and a
// request-level reference model of the cell-drawing rules.
module tb_char_blitter;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int NCHARS = 40;
  localparam int FB_AW  = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [5:0]       req_char;
  logic [6:0]       req_col;
  logic [5:0]       req_row;
  logic             charprint;
  logic [5:0]       character;
  logic [63:0]      vdata;
  logic             fb_we;
  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_wdata;
  logic             done;
  logic             err;

  char_blitter #(.COLS(COLS), .ROWS(ROWS), .NCHARS(NCHARS), .FB_AW(FB_AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_char(req_char), .req_col(req_col), .req_row(req_row),
    .charprint(charprint), .character(character), .vdata(vdata),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int nassert = 0;
  int nfail   = 0;
  int cyc     = 0;

  logic [63:0] rom [64];

  // Cycle stamp = index of the rising edge that samples the current value.
  always @(posedge clk) cyc <= cyc + 1;

  // ROM: data valid the cycle after the strobe is sampled; garbage otherwise.
  always @(posedge clk) vdata <= charprint ? rom[character] : {$urandom, $urandom};

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];
  int cp_cyc[$];
  int cp_char[$];
  int dn_cyc[$];
  int dn_err[$];

  always @(negedge clk) begin
    if (fb_we) begin
      wr_addr.push_back(int'(fb_addr));
      wr_data.push_back(int'(fb_wdata));
      wr_cyc.push_back(cyc + 1);
    end
    if (charprint) begin
      cp_cyc.push_back(cyc + 1);
      cp_char.push_back(int'(character));
    end
    if (done) begin
      dn_cyc.push_back(cyc + 1);
      dn_err.push_back(int'(err));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    cp_cyc.delete(); cp_char.delete(); dn_cyc.delete(); dn_err.delete();
  endtask

  function automatic bit is_bad(input int col, input int row);
    return (col >= COLS) || (row >= ROWS);
  endfunction

  function automatic int exp_writes(input int c, input int col, input int row);
    return is_bad(col, row) ? 0 : 8;
  endfunction

  function automatic int exp_fetches(input int c, input int col, input int row);
    return (is_bad(col, row) || c >= NCHARS) ? 0 : 1;
  endfunction

  // Compare one request's events against the model, starting at given queue offsets.
  task automatic check_req(input string tag, input int c, input int col, input int row,
                           input int t0, input int wb, input int cb, input int db);
    bit bad, blank;
    logic [63:0] glyph;
    bad   = is_bad(col, row);
    blank = !bad && (c >= NCHARS);
    glyph = blank ? 64'd0 : rom[c];
    if (exp_fetches(c, col, row) == 1 && cp_cyc.size() > cb) begin
      chk({tag, "_cp_cycle"}, cp_cyc[cb], t0 + 2);
      chk({tag, "_cp_char"}, cp_char[cb], c);
    end
    for (int i = 0; i < exp_writes(c, col, row); i++) begin
      if (wr_addr.size() > wb + i) begin
        chk({tag, "_wr_addr"}, wr_addr[wb+i], (row * 8 + i) * COLS + col);
        chk({tag, "_wr_data"}, wr_data[wb+i], glyph[63-8*i -: 8]);
        chk({tag, "_wr_cycle"}, wr_cyc[wb+i], t0 + (blank ? 3 : 4) + i);
      end
    end
    if (dn_cyc.size() > db) begin
      chk({tag, "_done_cycle"}, dn_cyc[db], t0 + (bad ? 2 : (blank ? 11 : 12)));
      chk({tag, "_err"}, dn_err[db], bad);
    end
  endtask

  task automatic send(input int c, input int col, input int row, output int t0);
    int n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_req", req_ready, 1'b1);
    req_valid = 1'b1;
    req_char  = 6'(c);
    req_col   = 7'(col);
    req_row   = 6'(row);
    t0 = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_dones(input string tag, input int want);
    int n = 0;
    while (dn_cyc.size() < want && n < 60) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, dn_cyc.size() >= want, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_req(input string tag, input int c, input int col, input int row);
    int t0;
    clear_mon();
    send(c, col, row, t0);
    wait_dones(tag, 1);
    chk({tag, "_n_writes"}, wr_addr.size(), exp_writes(c, col, row));
    chk({tag, "_n_fetch"}, cp_cyc.size(), exp_fetches(c, col, row));
    chk({tag, "_n_done"}, dn_cyc.size(), 1);
    check_req(tag, c, col, row, t0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, n, nw;
    for (int i = 0; i < 64; i++) rom[i] = {$urandom, $urandom};
    rom[5]    = 64'h183C66667E666600;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_char  = '0;
    req_col   = '0;
    req_row   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_charprint", charprint, 1'b0);
    chk("rst_character", character, 6'd0);
    chk("rst_fb_we", fb_we, 1'b0);
    chk("rst_fb_addr", fb_addr, 16'd0);
    chk("rst_fb_wdata", fb_wdata, 8'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed: known glyph, explicit addresses
    run_req("valid", 5, 3, 2);
    if (wr_addr.size() == 8) begin
      chk("valid_first_addr", wr_addr[0], 1283);
      chk("valid_last_addr", wr_addr[7], 1843);
      chk("valid_data4", wr_data[4], 8'h7E);
    end

    run_req("corner", 0, 79, 59);
    if (wr_addr.size() == 8) chk("corner_last_addr", wr_addr[7], 38399);

    run_req("blank", 45, 10, 20);
    run_req("bad_col", 3, 80, 5);
    run_req("bad_row", 3, 5, 60);
    run_req("blank_edge", NCHARS, 0, 0);
    run_req("last_glyph", NCHARS - 1, 40, 30);

    // Busy: valid held high across two requests
    clear_mon();
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_char = 6'd12; req_col = 7'd7; req_row = 6'd9;
    ta = cyc + 1;
    @(negedge clk);
    req_char = 6'd33; req_col = 7'd8; req_row = 6'd9;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    tb = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_second_accept", tb, ta + 12);
    wait_dones("busy", 2);
    chk("busy_n_writes", wr_addr.size(), 16);
    chk("busy_n_fetch", cp_cyc.size(), 2);
    chk("busy_n_done", dn_cyc.size(), 2);
    check_req("busy_a", 12, 7, 9, ta, 0, 0, 0);
    check_req("busy_b", 33, 8, 9, tb, 8, 1, 1);

    // Reset in the middle of the write burst
    clear_mon();
    send(7, 10, 10, ta);
    n = 0;
    while (wr_addr.size() < 3 && n < 30) begin @(negedge clk); n++; end
    chk("midrst_started", wr_addr.size() >= 3, 1'b1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_fb_we", fb_we, 1'b0);
    chk("midrst_charprint", charprint, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_ready", req_ready, 1'b1);
    chk("midrst_fb_addr", fb_addr, 16'd0);
    chk("midrst_fb_wdata", fb_wdata, 8'd0);
    nw = wr_addr.size();
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("midrst_no_more_writes", wr_addr.size(), nw);
    chk("midrst_no_done", dn_cyc.size(), 0);

    // Random requests against the model
    for (int k = 0; k < 24; k++) begin
      int rc, rcol, rrow;
      rc   = (($urandom % 4) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 39));
      rcol = (($urandom % 6) == 0) ? int'($urandom_range(80, 127)) : int'($urandom_range(0, 79));
      rrow = (($urandom % 6) == 0) ? int'($urandom_range(60, 63)) : int'($urandom_range(0, 59));
      run_req("rand", rc, rcol, rrow);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
